// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard scoreboard.
package pipe_pkg;

  // Forward-select value meaning "take the operand from the register file".
  localparam int FWD_RF   = 0;
  // Stage indices counted from ID: EX = 1, MEM = 2, WB = 3.
  localparam int STG_EX   = 1;
  localparam int STG_MEM  = 2;
  localparam int STG_WB   = 3;

  // Producer latencies: ALU results forward from EX, load results from MEM.
  localparam int LAT_ALU  = 1;
  localparam int LAT_LOAD = 2;

  // Entry fields are sized for the largest supported configuration;
  // narrower instances zero-extend into them.
  localparam int ENT_AW   = 8;
  localparam int ENT_LW   = 4;

  typedef struct packed {
    logic              valid;
    logic [ENT_AW-1:0] dst;
    logic [ENT_LW-1:0] lat;
  } entry_t;

endpackage

// File: rtl/sb_src_check.sv
// Checks one source operand against every tracked in-flight write.
// The youngest matching entry decides: hazard if its result is not ready
// yet, otherwise its stage index becomes the forward select.
module sb_src_check
  import pipe_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3
) (
  input  entry_t [DEPTH-1:0] ents,      // index s-1 holds stage s
  input  logic [REG_AW-1:0]  src_addr,
  input  logic               src_used,
  output logic               hazard,
  output logic [1:0]         fwd_sel
);

  logic              hit;
  logic [ENT_LW-1:0] hit_s;
  logic [ENT_LW-1:0] hit_lat;

  // Priority search: scan oldest to youngest so the youngest match is kept.
  always_comb begin
    hit     = 1'b0;
    hit_s   = '0;
    hit_lat = '0;
    for (int s = DEPTH; s >= 1; s--) begin
      if (ents[s-1].valid && (ents[s-1].dst == ENT_AW'(src_addr))) begin
        hit     = 1'b1;
        hit_s   = ENT_LW'(s);
        hit_lat = ents[s-1].lat;
      end
    end
  end

  // Register 0 and unread operands never depend on anything.
  always_comb begin
    hazard  = 1'b0;
    fwd_sel = 2'(FWD_RF);
    if (src_used && (src_addr != '0) && hit) begin
      if (hit_s < hit_lat) hazard = 1'b1;
      else                 fwd_sel = hit_s[1:0];
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Load-use hazard detector and forwarding selector for the ID stage.
// Tracks in-flight register writes in a DEPTH-entry shift register and
// raises stall whenever a read source depends on a result that is not yet
// forwardable; otherwise tells the EX operand muxes which stage to use.
//
// stall is a same-cycle, combinational request: while it is high the ID
// instruction holds and a bubble enters stage 1 on the next edge.
module hazard_scoreboard
  import pipe_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 3,
  parameter int LAT_W   = 2,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      Rst,
  input  logic                      issue_valid,
  input  logic                      issue_wr,
  input  logic [REG_AW-1:0]         issue_dst,
  input  logic [LAT_W-1:0]          issue_lat,
  input  logic [NUM_SRC*REG_AW-1:0] src_addr,
  input  logic [NUM_SRC-1:0]        src_used,
  input  logic                      flush_ex,
  output logic                      stall,
  output logic [NUM_SRC*2-1:0]      fwd_sel,
  output logic [CNT_W-1:0]          stall_cnt
);

  entry_t [DEPTH-1:0] ent_q, ent_d, ent_view;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [NUM_SRC-1:0] hazard;

  // A flushed EX instruction will never produce its result, so it must not
  // cause a stall or a forward in the cycle it is killed either.
  always_comb begin
    ent_view = ent_q;
    if (flush_ex) ent_view[STG_EX-1].valid = 1'b0;
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    sb_src_check #(
      .REG_AW (REG_AW),
      .DEPTH  (DEPTH)
    ) u_chk (
      .ents     (ent_view),
      .src_addr (src_addr[g*REG_AW +: REG_AW]),
      .src_used (src_used[g]),
      .hazard   (hazard[g]),
      .fwd_sel  (fwd_sel[g*2 +: 2])
    );
  end

  assign stall     = issue_valid & (|hazard);
  assign stall_cnt = stall_cnt_q;

  // Next state: shift entries one stage older, load the issuing instruction
  // (or a bubble) into stage 1, and count stalled cycles with saturation.
  always_comb begin
    ent_d          = ent_q;
    ent_d[0].valid = issue_valid & ~stall & issue_wr & (issue_dst != '0);
    ent_d[0].dst   = ENT_AW'(issue_dst);
    ent_d[0].lat   = (issue_lat == '0) ? ENT_LW'(LAT_ALU) : ENT_LW'(issue_lat);
    for (int s = 2; s <= DEPTH; s++) begin
      ent_d[s-1] = ent_q[s-2];
      if ((s == STG_MEM) && flush_ex) ent_d[s-1].valid = 1'b0;
    end
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      ent_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      ent_q       <= ent_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed vector table, randomized traffic
// against a producer-list reference model, counter saturation and
// asynchronous reset sequences.
module tb_hazard_scoreboard;
  import pipe_pkg::*;

  localparam int AW    = 5;
  localparam int NS    = 2;
  localparam int DEPTH = 3;
  localparam int LW    = 2;
  localparam int CW    = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic Rst;
  always #5 clk = ~clk;

  logic             issue_valid, issue_wr, flush_ex;
  logic [AW-1:0]    issue_dst;
  logic [LW-1:0]    issue_lat;
  logic [NS*AW-1:0] src_addr;
  logic [NS-1:0]    src_used;
  logic             stall;
  logic [NS*2-1:0]  fwd_sel;
  logic [CW-1:0]    stall_cnt;

  hazard_scoreboard #(
    .REG_AW(AW), .NUM_SRC(NS), .DEPTH(DEPTH), .LAT_W(LW), .CNT_W(CW)
  ) dut (
    .clk(clk), .Rst(Rst),
    .issue_valid(issue_valid), .issue_wr(issue_wr),
    .issue_dst(issue_dst), .issue_lat(issue_lat),
    .src_addr(src_addr), .src_used(src_used), .flush_ex(flush_ex),
    .stall(stall), .fwd_sel(fwd_sel), .stall_cnt(stall_cnt)
  );

  // ---------------- vectors ----------------
  typedef struct {
    logic       iv;
    logic       wr;
    logic [4:0] dst;
    logic [1:0] lat;
    logic [4:0] a0;
    logic [4:0] a1;
    logic [1:0] used;
    logic       flush;
    logic       e_stall;
    logic [1:0] e_f0;
    logic [1:0] e_f1;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(logic iv, logic wr, logic [4:0] dst, logic [1:0] lat,
                              logic [4:0] a0, logic [4:0] a1, logic [1:0] used,
                              logic flush, logic st, logic [1:0] f0, logic [1:0] f1);
    vec_t v;
    v.iv = iv; v.wr = wr; v.dst = dst; v.lat = lat; v.a0 = a0; v.a1 = a1;
    v.used = used; v.flush = flush; v.e_stall = st; v.e_f0 = f0; v.e_f1 = f1;
    return v;
  endfunction

  // ---------------- reference model ----------------
  // In-flight producers kept as a list with the cycle they left ID;
  // a producer's stage is simply its age in cycles.
  typedef struct {
    logic [4:0] dst;
    logic [1:0] lat;
    int         birth;
  } prod_t;

  prod_t      inflight[$];
  int         cyc;
  bit         m_stall;
  logic [3:0] m_fwd;
  int         m_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void model_reset();
    inflight.delete();
    cyc   = 0;
    m_cnt = 0;
  endfunction

  function automatic void model_eval();
    bit hz = 0;
    m_fwd = '0;
    for (int i = 0; i < NS; i++) begin
      logic [4:0] addr;
      int best, blat;
      addr = src_addr[i*AW +: AW];
      best = 0;
      blat = 0;
      if (src_used[i] && addr != 0) begin
        foreach (inflight[k]) begin
          int age;
          age = cyc - inflight[k].birth;
          if (inflight[k].dst == addr && age >= 1 && age <= DEPTH &&
              !(age == 1 && flush_ex) && (best == 0 || age < best)) begin
            best = age;
            blat = (inflight[k].lat == 0) ? 1 : int'(inflight[k].lat);
          end
        end
        if (best != 0) begin
          if (best < blat) hz = 1;
          else m_fwd[i*2 +: 2] = 2'(best);
        end
      end
    end
    m_stall = issue_valid && hz;
  endfunction

  function automatic void model_update();
    if (m_stall && m_cnt != (1 << CW) - 1) m_cnt++;
    for (int k = inflight.size() - 1; k >= 0; k--) begin
      int age;
      age = cyc - inflight[k].birth;
      if (age >= DEPTH || (age == 1 && flush_ex)) inflight.delete(k);
    end
    if (issue_valid && !m_stall && issue_wr && issue_dst != 0) begin
      prod_t p;
      p.dst = issue_dst; p.lat = issue_lat; p.birth = cyc;
      inflight.push_back(p);
    end
    cyc++;
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    issue_valid = v.iv;
    issue_wr    = v.wr;
    issue_dst   = v.dst;
    issue_lat   = v.lat;
    src_addr    = {v.a1, v.a0};
    src_used    = v.used;
    flush_ex    = v.flush;
  endtask

  // Sample on the falling edge, then advance the model with the rising edge.
  task automatic run_cycle(input string tag, input bit use_exp, input vec_t v);
    @(negedge clk);
    model_eval();
    if (use_exp) begin
      check({tag, " stall"}, 32'(stall), 32'(v.e_stall));
      check({tag, " fwd"}, 32'(fwd_sel), 32'({v.e_f1, v.e_f0}));
    end else begin
      check({tag, " stall"}, 32'(stall), 32'(m_stall));
      check({tag, " fwd"}, 32'(fwd_sel), 32'(m_fwd));
    end
    check({tag, " cnt"}, 32'(stall_cnt), 32'(m_cnt));
    @(posedge clk);
    model_update();
    #1;
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    v = mk($urandom_range(0, 1), $urandom_range(0, 1), 5'($urandom_range(0, 7)),
           2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0), 0, 0, 0);
    return v;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    vec_t v;
    //          iv wr dst lat a0  a1 used fl  st f0 f1
    vecs[0]  = mk(1, 1, 3,  1, 0,  0, 2'b00, 0, 0, 0, 0); // add r3
    vecs[1]  = mk(1, 0, 0,  1, 3,  0, 2'b01, 0, 0, 1, 0); // read r3 -> EX
    vecs[2]  = mk(1, 1, 5,  LAT_LOAD, 0, 0, 2'b00, 0, 0, 0, 0); // lw r5
    vecs[3]  = mk(1, 1, 7,  1, 5,  3, 2'b11, 0, 1, 0, 3); // load-use stall
    vecs[4]  = mk(1, 1, 7,  1, 5,  3, 2'b11, 0, 0, 2, 0); // then from MEM
    vecs[5]  = mk(1, 1, 4,  1, 0,  0, 2'b00, 0, 0, 0, 0); // add r4
    vecs[6]  = mk(1, 1, 4,  1, 0,  0, 2'b00, 0, 0, 0, 0); // sub r4
    vecs[7]  = mk(1, 0, 0,  1, 4,  4, 2'b11, 0, 0, 1, 1); // youngest wins
    vecs[8]  = mk(1, 1, 0,  2, 0,  0, 2'b00, 0, 0, 0, 0); // write r0
    vecs[9]  = mk(1, 0, 0,  1, 0,  4, 2'b01, 0, 0, 0, 0); // r0 read, r4 unused
    vecs[10] = mk(1, 1, 6,  2, 0,  0, 2'b00, 0, 0, 0, 0); // lw r6
    vecs[11] = mk(1, 0, 0,  1, 6,  0, 2'b01, 1, 0, 0, 0); // flushed producer
    vecs[12] = mk(1, 0, 0,  1, 6,  0, 2'b01, 0, 0, 0, 0);
    vecs[13] = mk(1, 0, 0,  1, 6,  0, 2'b01, 0, 0, 0, 0);
    vecs[14] = mk(1, 1, 9,  1, 0,  0, 2'b00, 1, 0, 0, 0); // issue during flush
    vecs[15] = mk(1, 0, 0,  1, 9,  0, 2'b01, 0, 0, 1, 0);
    vecs[16] = mk(1, 1, 10, 0, 0,  0, 2'b00, 0, 0, 0, 0); // lat 0 acts as 1
    vecs[17] = mk(1, 0, 0,  1, 10, 9, 2'b11, 0, 0, 1, 3);
    vecs[18] = mk(1, 1, 11, 3, 0,  0, 2'b00, 0, 0, 0, 0); // lat = DEPTH
    vecs[19] = mk(1, 0, 0,  1, 11, 0, 2'b01, 0, 1, 0, 0);
    vecs[20] = mk(1, 0, 0,  1, 11, 0, 2'b01, 0, 1, 0, 0);
    vecs[21] = mk(1, 0, 0,  1, 11, 0, 2'b01, 0, 0, 3, 0);

    // Reset held with random inputs: outputs must stay quiet.
    Rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      drive(rand_vec());
      @(negedge clk);
      check("reset stall", 32'(stall), 32'd0);
      check("reset fwd", 32'(fwd_sel), 32'd0);
      check("reset cnt", 32'(stall_cnt), 32'd0);
    end
    @(posedge clk);
    #1;
    Rst = 1'b1;
    model_reset();

    // Directed table.
    for (int i = 0; i < 22; i++) begin
      drive(vecs[i]);
      run_cycle($sformatf("vec%0d", i), 1, vecs[i]);
    end
    check("table stall count", 32'(stall_cnt), 32'd3);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      v = rand_vec();
      drive(v);
      run_cycle("rand", 0, v);
    end

    // Twenty forced stalls: producer with lat 3, consumer stalls twice each.
    for (int i = 0; i < 10; i++) begin
      v = mk(1, 1, 12, 3, 0, 0, 2'b00, 0, 0, 0, 0);
      drive(v);
      run_cycle("sat prod", 0, v);
      v = mk(1, 0, 0, 1, 12, 0, 2'b01, 0, 0, 0, 0);
      drive(v);
      for (int j = 0; j < 3; j++) run_cycle("sat cons", 0, v);
    end
    check("saturated cnt", 32'(stall_cnt), 32'd15);

    // Asynchronous reset in the middle of a load-use stall.
    v = mk(1, 1, 5, LAT_LOAD, 0, 0, 2'b00, 0, 0, 0, 0);
    drive(v);
    run_cycle("arst prod", 0, v);
    drive(mk(1, 0, 0, 1, 5, 0, 2'b01, 0, 0, 0, 0));
    #2;
    check("pre-arst stall", 32'(stall), 32'd1);
    Rst = 1'b0;
    #1;
    check("arst stall", 32'(stall), 32'd0);
    check("arst fwd", 32'(fwd_sel), 32'd0);
    check("arst cnt", 32'(stall_cnt), 32'd0);
    @(posedge clk);
    #1;
    check("arst hold stall", 32'(stall), 32'd0);
    Rst = 1'b1;
    model_reset();
    v = mk(0, 0, 0, 0, 5, 0, 2'b01, 0, 0, 0, 0);
    drive(v);
    run_cycle("post-arst", 1, v);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the fixed load-use hazard detector and forwarding unit of the 5-stage pipelineCPU.
- Tracks in-flight register writes in a shift register of DEPTH entries, one per stage past ID.
- Issues the ID-stage stall and per-source forward selects for any result latency.
- Sits beside ID; its outputs feed the PC/IF_ID stall, the ID_EX bubble insert and the EX operand muxes via ID_EX.

Parameters:
- REG_AW, 5: register address width.
- NUM_SRC, 2: source operands checked per instruction.
- DEPTH, 3: tracked stages past ID (EX, MEM, WB).
- LAT_W, 2: width of the producer latency field.
- CNT_W, 16: stall performance counter width.

Ports:
- clk  in  1  clock, rising edge.
- Rst  in  1  reset, asynchronous, active-low.
- issue_valid  in  1  instruction in ID wants to advance to EX.
- issue_wr  in  1  that instruction writes a register.
- issue_dst  in  REG_AW  its destination register.
- issue_lat  in  LAT_W  stages until its result is forwardable (1 = ALU, 2 = load).
- src_addr  in  NUM_SRC*REG_AW  source registers of the ID instruction; source i occupies bits [i*REG_AW +: REG_AW].
- src_used  in  NUM_SRC  per-source "operand actually read" flag.
- flush_ex  in  1  kill the instruction currently in EX (stage-1 entry).
- stall  out  1  hold PC and IF_ID; insert bubble into ID_EX.
- fwd_sel  out  NUM_SRC*2  per source: 0 = register file, otherwise the stage index supplying the value.
- stall_cnt  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Entry state, for s = 1..DEPTH: valid[s], dst[s], lat[s]. Entry s is the instruction s cycles past ID.
- Reset (Rst = 0, asynchronous):
  - all valid cleared; stall_cnt = 0.
  - stall and fwd_sel are combinational from the entries, so both read 0 during and after reset.
- Match rule:
  - source i matches entry s when src_used[i], valid[s], dst[s] == src_addr[i], and src_addr[i] != 0.
  - Register 0 never matches.
- Per source, only the youngest (lowest s) matching entry counts.
  - If s < lat[s]: hazard.
  - Otherwise fwd_sel[i] = s.
  - No match: fwd_sel[i] = 0.
  - Entries at s = DEPTH count as matches. The register file is write-before-read, so retired entries need no tracking.
- stall = issue_valid AND (any source has a hazard). Combinational, same cycle.
- Each rising edge:
  - Entry s moves to s+1; entry DEPTH retires.
  - New entry 1 is valid = issue_valid & ~stall & issue_wr & (issue_dst != 0), with dst and lat loaded from the issue inputs.
  - When stall is high, a bubble (valid = 0) enters entry 1 and the ID instruction stays in place.
- flush_ex: the entry moving from stage 1 to stage 2 this edge becomes invalid. A simultaneous issue still enters stage 1 normally.
- issue_lat = 0 is treated as 1.
- issue_lat > DEPTH: the producer stalls every consumer until it retires.
- stall_cnt increments on each edge where stall = 1 and holds at 2^CNT_W - 1 (no wrap).
- Load-use with defaults:
  - lw in EX (s = 1, lat = 2) with a dependent instruction in ID: stall for 1 cycle.
  - Next cycle the load is at s = 2, so fwd_sel = 2 (MEM/WB path).

Decomposition:
- Shared package pipe_pkg holds:
  - FWD_RF = 0 and the stage-index constants.
  - LAT_ALU = 1, LAT_LOAD = 2.
  - a packed entry struct {valid, dst, lat}.
- One sub-module, sb_src_check: priority match of one source against all entries, producing hazard and fwd_sel. It is instantiated NUM_SRC times with a generate loop.

Test Plan:
- Reset: hold Rst = 0 with random inputs -> stall = 0, fwd_sel = 0, stall_cnt = 0; release, issue add r3 (lat 1), next cycle source r3 -> fwd_sel = 1, stall = 0.
- Load-use: issue lw r5 (lat 2), next cycle source r5 used -> stall = 1 for exactly 1 cycle, then fwd_sel = 2; stall_cnt = 1.
- Youngest wins: issue add r4, then sub r4 on consecutive cycles, then read r4 -> fwd_sel = 1, not 2.
- Register 0 and unused sources: producer writes r0; consumer reads r0 -> no stall, fwd_sel = 0; src_used = 0 on a matching r5 -> fwd_sel = 0.
- flush_ex: issue lw r6; assert flush_ex on the next edge while the consumer reads r6 -> no stall, fwd_sel = 0 two cycles later.
- Saturation and async reset: with CNT_W = 4, force 20 stall cycles -> stall_cnt = 15; drop Rst mid-cycle -> entries and counter clear immediately, with no clock edge.
